// File: rtl/raif_arbiter.sv
// raif_arbiter: independent read/write SDRAM arbiters; CHANNEL_NUM client req_/addr_/num_/data_ slices are round-robin muxed (fixed priority with RAIF_ARB_FIXED_PRIO_EN) onto one rd/wr port, and grant/finish are routed back to the owner only
module raif_arbiter #(
  parameter int APP_DATA_WIDTH = 16,
  parameter int APP_ADDR_WIDTH = 24,
  parameter int CHANNEL_NUM = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNEL_NUM-1:0]               rd_req_,
  input  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] rd_addr_,
  input  logic [10*CHANNEL_NUM-1:0]            rd_num_,
  output logic [APP_DATA_WIDTH*CHANNEL_NUM-1:0] rd_data_,
  output logic [CHANNEL_NUM-1:0]               rd_grant_,
  output logic [CHANNEL_NUM-1:0]               rd_finish_,
  input  logic [CHANNEL_NUM-1:0]               wr_req_,
  input  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] wr_addr_,
  input  logic [10*CHANNEL_NUM-1:0]            wr_num_,
  input  logic [APP_DATA_WIDTH*CHANNEL_NUM-1:0] wr_data_,
  output logic [CHANNEL_NUM-1:0]               wr_grant_,
  output logic [CHANNEL_NUM-1:0]               wr_finish_,
  output logic                                 rd_req,
  output logic [APP_ADDR_WIDTH-1:0]            rd_addr,
  output logic [9:0]                           rd_num,
  input  logic [APP_DATA_WIDTH-1:0]            rd_data,
  input  logic                                 rd_grant,
  input  logic                                 rd_finish,
  output logic                                 wr_req,
  output logic [APP_ADDR_WIDTH-1:0]            wr_addr,
  output logic [9:0]                           wr_num,
  output logic [APP_DATA_WIDTH-1:0]            wr_data,
  input  logic                                 wr_grant,
  input  logic                                 wr_finish
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;
  localparam int OW = CHANNEL_NUM > 1 ? $clog2(CHANNEL_NUM) : 1;
  function automatic logic [OW-1:0] wrap(input int v);
    return OW'(v % CHANNEL_NUM);
  endfunction
  logic [1:0][CHANNEL_NUM-1:0] req_v, grant_v, finish_v;
  logic [1:0][APP_ADDR_WIDTH*CHANNEL_NUM-1:0] addr_v;
  logic [1:0][10*CHANNEL_NUM-1:0] num_v;
  logic [1:0] dn_grant, dn_finish, dn_req;
  logic [1:0][APP_ADDR_WIDTH-1:0] dn_addr;
  logic [1:0][9:0] dn_num;
  assign req_v = {wr_req_, rd_req_};
  assign addr_v = {wr_addr_, rd_addr_};
  assign num_v = {wr_num_, rd_num_};
  assign dn_grant = {wr_grant, rd_grant};
  assign dn_finish = {wr_finish, rd_finish};
  assign {wr_req, rd_req} = dn_req;
  assign {wr_addr, rd_addr} = dn_addr;
  assign {wr_num, rd_num} = dn_num;
  assign {wr_grant_, rd_grant_} = grant_v;
  assign {wr_finish_, rd_finish_} = finish_v;
  assign rd_data_ = {CHANNEL_NUM{rd_data}};
  for (genvar d = 0; d < 2; d++) begin : g_arb
    state_e state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, sel;
    logic busy, any;
    assign any = |req_v[d];
    assign busy = state_q == BUSY;
    always_comb begin
      sel = '0;
      for (int i = CHANNEL_NUM - 1; i >= 0; i--)
`ifdef RAIF_ARB_FIXED_PRIO_EN
        if (req_v[d][wrap(i)]) sel = wrap(i);
`else
        if (req_v[d][wrap(int'(ptr_q) + i)]) sel = wrap(int'(ptr_q) + i);
`endif
    end
    always_comb begin
      state_d = state_q == IDLE ? (any ? BUSY : IDLE) : state_q == BUSY ? (dn_finish[d] ? RELEASE : BUSY) : IDLE;
      owner_d = state_q == IDLE && any ? sel : owner_q;
      ptr_d = busy && dn_finish[d] ? wrap(int'(owner_q) + 1) : ptr_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q <= ptr_d;
      end
    end
    assign dn_req[d] = busy;
    assign dn_addr[d] = busy ? addr_v[d][int'(owner_q)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH] : '0;
    assign dn_num[d] = busy ? num_v[d][int'(owner_q)*10 +: 10] : '0;
    assign grant_v[d] = busy && dn_grant[d] ? CHANNEL_NUM'(1) << owner_q : '0;
    assign finish_v[d] = busy && dn_finish[d] ? CHANNEL_NUM'(1) << owner_q : '0;
    if (d == 1) begin : g_wdata
      assign wr_data = busy ? wr_data_[int'(owner_q)*APP_DATA_WIDTH +: APP_DATA_WIDTH] : '0;
    end
  end
endmodule

// File: tb/tb_raif_arbiter.sv
// tb_raif_arbiter: table vectors, round-robin sequence and randomized stress of raif_arbiter against a behavioural model
module tb_raif_arbiter;
  localparam int DW = 16, AW = 24, N = 2;
`ifdef RAIF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1;
`else
  localparam bit FIXED = 0;
`endif
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] rd_req_, wr_req_, rd_grant_, rd_finish_, wr_grant_, wr_finish_;
  logic [AW*N-1:0] rd_addr_, wr_addr_;
  logic [10*N-1:0] rd_num_, wr_num_;
  logic [DW*N-1:0] rd_data_, wr_data_;
  logic rd_req, wr_req, rd_grant, rd_finish, wr_grant, wr_finish;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [9:0] rd_num, wr_num;
  logic [DW-1:0] rd_data, wr_data;
  raif_arbiter #(.APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .CHANNEL_NUM(N)) dut (
    .clk(clk), .rst(rst),
    .rd_req_(rd_req_), .rd_addr_(rd_addr_), .rd_num_(rd_num_), .rd_data_(rd_data_),
    .rd_grant_(rd_grant_), .rd_finish_(rd_finish_),
    .wr_req_(wr_req_), .wr_addr_(wr_addr_), .wr_num_(wr_num_), .wr_data_(wr_data_),
    .wr_grant_(wr_grant_), .wr_finish_(wr_finish_),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_num(rd_num), .rd_data(rd_data),
    .rd_grant(rd_grant), .rd_finish(rd_finish),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_num(wr_num), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_finish(wr_finish)
  );
  int vecs = 0, errs = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic rst;
    logic [1:0] rrq, wrq;
    logic rg, rf, wg, wf;
    logic er, ew;
    logic [1:0] erg, erf, ewg, ewf;
    logic [23:0] eaddr;
    logic [9:0] e_num;
  } vec_t;
  vec_t tbl[19];
  int m_ph[2], m_own[2], m_ptr[2];
  logic [N-1:0] cl_req[2], prev_g[2];
  bit cl_cool[2][N];
  int rq_cnt[2][N], fin_cnt[2][N], bst_cnt[2][N];
  int rsp_cnt[2], rsp_len[2];
  int order[$];
  function automatic int pick(input logic [N-1:0] r, input int p);
    if (FIXED) p = 0;
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  task automatic do_reset();
    rst = 1;
    rd_req_ = '0; wr_req_ = '0;
    rd_grant = 0; rd_finish = 0; wr_grant = 0; wr_finish = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = 0; m_own[d] = 0; m_ptr[d] = 0;
      cl_req[d] = '0; prev_g[d] = '0;
      rsp_cnt[d] = 0; rsp_len[d] = 2;
      for (int c = 0; c < N; c++) cl_cool[d][c] = 0;
    end
  endtask
  task automatic tick(input int pct, input bit log_wr, input bit rand_wd);
    logic dq[2];
    logic [1:0] g, f;
    bit b0, b1;
    dq[0] = rd_req; dq[1] = wr_req;
    for (int d = 0; d < 2; d++) begin
      g[d] = 0; f[d] = 0;
      if (dq[d]) begin
        if (rsp_cnt[d] < rsp_len[d]) begin
          g[d] = 1; rsp_cnt[d]++;
        end else begin
          f[d] = 1; rsp_cnt[d] = 0; rsp_len[d] = $urandom_range(4, 1);
        end
      end else if ($urandom_range(99) < 3) begin
        g[d] = 1'($urandom_range(1)); f[d] = 1'($urandom_range(1));
      end
      for (int c = 0; c < N; c++)
        if (!cl_req[d][c]) begin
          if (cl_cool[d][c]) cl_cool[d][c] = 0;
          else if ($urandom_range(99) < pct) begin
            cl_req[d][c] = 1; rq_cnt[d][c]++;
          end
        end
    end
    rd_req_ = cl_req[0]; wr_req_ = cl_req[1];
    rd_grant = g[0]; rd_finish = f[0]; wr_grant = g[1]; wr_finish = f[1];
    rd_addr_ = (AW*N)'({$urandom(), $urandom()});
    wr_addr_ = (AW*N)'({$urandom(), $urandom()});
    rd_num_ = (10*N)'($urandom());
    wr_num_ = (10*N)'($urandom());
    rd_data = DW'($urandom());
    if (rand_wd) wr_data_ = (DW*N)'($urandom());
    #1;
    b0 = m_ph[0] == 1; b1 = m_ph[1] == 1;
    chk("rd_req", rd_req, b0);
    chk("rd_addr", rd_addr, b0 ? rd_addr_[m_own[0]*AW +: AW] : 0);
    chk("rd_num", rd_num, b0 ? rd_num_[m_own[0]*10 +: 10] : 0);
    chk("rd_grant_", rd_grant_, b0 && g[0] ? N'(1) << m_own[0] : 0);
    chk("rd_finish_", rd_finish_, b0 && f[0] ? N'(1) << m_own[0] : 0);
    chk("rd_data_", rd_data_, {N{rd_data}});
    chk("wr_req", wr_req, b1);
    chk("wr_addr", wr_addr, b1 ? wr_addr_[m_own[1]*AW +: AW] : 0);
    chk("wr_num", wr_num, b1 ? wr_num_[m_own[1]*10 +: 10] : 0);
    chk("wr_data", wr_data, b1 ? wr_data_[m_own[1]*DW +: DW] : 0);
    chk("wr_grant_", wr_grant_, b1 && g[1] ? N'(1) << m_own[1] : 0);
    chk("wr_finish_", wr_finish_, b1 && f[1] ? N'(1) << m_own[1] : 0);
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] og, of, ef;
      og = d == 0 ? rd_grant_ : wr_grant_;
      of = d == 0 ? rd_finish_ : wr_finish_;
      ef = m_ph[d] == 1 && f[d] ? N'(1) << m_own[d] : '0;
      for (int c = 0; c < N; c++) begin
        if (og[c] && !prev_g[d][c]) bst_cnt[d][c]++;
        if (of[c]) fin_cnt[d][c]++;
        if (ef[c]) begin
          cl_req[d][c] = 0; cl_cool[d][c] = 1;
        end
      end
      prev_g[d] = og;
    end
    if (log_wr) for (int c = 0; c < N; c++) if (wr_finish_[c]) order.push_back(c);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] r;
      r = d == 0 ? rd_req_ : wr_req_;
      if (rst) begin
        m_ph[d] = 0; m_own[d] = 0; m_ptr[d] = 0;
      end else if (m_ph[d] == 0) begin
        if (|r) begin
          m_own[d] = pick(r, m_ptr[d]); m_ph[d] = 1;
        end
      end else if (m_ph[d] == 1) begin
        if (f[d]) begin
          m_ph[d] = 2; m_ptr[d] = (m_own[d] + 1) % N;
        end
      end else m_ph[d] = 0;
    end
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, 2'b11, 2'b11, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[1]  = '{1, 2'b11, 2'b11, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[2]  = '{0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[3]  = '{0, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd86, 10'd86};
    tbl[4]  = '{0, 2'b10, 2'b00, 1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 24'd86, 10'd86};
    tbl[5]  = '{0, 2'b10, 2'b00, 1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 24'd86, 10'd86};
    tbl[6]  = '{0, 2'b10, 2'b00, 0, 1, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b00, 24'd86, 10'd86};
    tbl[7]  = '{0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[8]  = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[9]  = '{0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[10] = '{0, 2'b01, 2'b01, 1, 0, 1, 0, 1, 1, 2'b01, 2'b00, 2'b01, 2'b00, 24'h123, 10'd5};
    tbl[11] = '{0, 2'b00, 2'b01, 0, 1, 0, 0, 1, 1, 2'b00, 2'b01, 2'b00, 2'b00, 24'h123, 10'd5};
    tbl[12] = '{0, 2'b00, 2'b01, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 24'd0, 10'd0};
    tbl[13] = '{0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[14] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[15] = '{0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[16] = '{1, 2'b10, 2'b00, 1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 24'd86, 10'd86};
    tbl[17] = '{0, 2'b10, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 24'd0, 10'd0};
    tbl[18] = '{0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b00, 24'd86, 10'd86};
    rd_addr_ = {24'd86, 24'h000123};
    rd_num_ = {10'd86, 10'd5};
    wr_addr_ = {24'h000789, 24'h000456};
    wr_num_ = {10'd9, 10'd7};
    wr_data_ = {16'h1111, 16'hffff};
    rd_data = 16'h5a5a;
    rst = 1; rd_req_ = '1; wr_req_ = '1;
    rd_grant = 0; rd_finish = 0; wr_grant = 0; wr_finish = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; rd_req_ = tbl[i].rrq; wr_req_ = tbl[i].wrq;
      rd_grant = tbl[i].rg; rd_finish = tbl[i].rf; wr_grant = tbl[i].wg; wr_finish = tbl[i].wf;
      #1;
      chk($sformatf("t%0d rd_req", i), rd_req, tbl[i].er);
      chk($sformatf("t%0d wr_req", i), wr_req, tbl[i].ew);
      chk($sformatf("t%0d rd_grant_", i), rd_grant_, tbl[i].erg);
      chk($sformatf("t%0d rd_finish_", i), rd_finish_, tbl[i].erf);
      chk($sformatf("t%0d wr_grant_", i), wr_grant_, tbl[i].ewg);
      chk($sformatf("t%0d wr_finish_", i), wr_finish_, tbl[i].ewf);
      chk($sformatf("t%0d rd_addr", i), rd_addr, tbl[i].eaddr);
      chk($sformatf("t%0d rd_num", i), rd_num, tbl[i].e_num);
      @(posedge clk); #1;
    end
    do_reset();
    wr_data_ = {16'h1111, 16'hffff};
    for (int k = 0; k < 400 && order.size() < 10; k++) tick(100, 1, 0);
    chk("rr transfers", order.size(), 10);
    for (int k = 0; k < 10 && k < order.size(); k++)
      chk($sformatf("rr owner %0d", k), order[k], FIXED ? 0 : k % 2);
    do_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        rq_cnt[d][c] = 0; fin_cnt[d][c] = 0; bst_cnt[d][c] = 0;
      end
    for (int k = 0; k < 20000; k++) tick(1, 0, 1);
    for (int k = 0; k < 2000; k++) tick(30, 0, 1);
    for (int k = 0; k < 300; k++) tick(0, 0, 1);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        chk($sformatf("dir%0d ch%0d finishes", d, c), fin_cnt[d][c], rq_cnt[d][c]);
        chk($sformatf("dir%0d ch%0d bursts", d, c), bst_cnt[d][c], rq_cnt[d][c]);
      end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
